// File: rtl/w0rm_timer_arbiter.sv
// w0rm_timer_arbiter: round-robin scheduler that shares one timed unit
// (start/stop handshake) between NUM_REQ requesters, with a watchdog.
// Every output is a register loaded from the state the FSM held in the
// previous cycle. So grant/unit_start appear one edge after the state enters
// START, and done/timeout_err appear one edge after it enters DONE.
module w0rm_timer_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               unit_start,
  input  logic               unit_stop,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WD_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [WD_W-1:0]  WD_MAX     = {WD_W{1'b1}};
  localparam logic [WD_W-1:0]  WD_EXPIRE  = WD_W'(WD_LIM);
  localparam logic [PTR_W:0]   NREQ_EXT   = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam bit               WD_ENABLED = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   r_gidx;
  logic [PTR_W-1:0]   w_gidx_nxt;
  logic [WD_W-1:0]    r_wd;
  logic [WD_W-1:0]    w_wd_nxt;
  logic               r_to;
  logic               w_to_nxt;

  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               r_unit_start;
  logic               w_unit_start_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_timeout_err;
  logic               w_timeout_err_nxt;

  logic [NUM_REQ-1:0] w_req_rot;
  logic [PTR_W-1:0]   w_off;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_gnt_oh;

  assign grant       = r_grant;
  assign done        = r_done;
  assign unit_start  = r_unit_start;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

  assign w_gnt_oh = NUM_REQ'(1) << r_gidx;

  // Round-robin pick: rotate req so bit 0 is the pointer, take the lowest set
  // bit, then map the offset back to an absolute index with wrap-around.
  always_comb begin
    w_req_rot = NUM_REQ'({req, req} >> r_ptr);
    w_off     = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = PTR_W'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= NREQ_EXT) begin
      w_pick = PTR_W'(w_sum - NREQ_EXT);
    end else begin
      w_pick = PTR_W'(w_sum);
    end
  end

  // Next-state and next-output logic for IDLE -> START -> WAIT -> DONE.
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_gidx_nxt        = r_gidx;
    w_wd_nxt          = r_wd;
    w_to_nxt          = r_to;
    w_grant_nxt       = '0;
    w_done_nxt        = '0;
    w_unit_start_nxt  = 1'b0;
    w_busy_nxt        = 1'b0;
    w_timeout_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gidx_nxt  = w_pick;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        w_grant_nxt      = w_gnt_oh;
        w_unit_start_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
        w_wd_nxt         = '0;
        w_to_nxt         = 1'b0;
        w_state_nxt      = S_WAIT;
      end

      S_WAIT: begin
        w_grant_nxt = w_gnt_oh;
        w_busy_nxt  = 1'b1;
        if (r_wd != WD_MAX) begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
        // A real stop beats a simultaneous watchdog expiry.
        if (unit_stop) begin
          w_to_nxt    = 1'b0;
          w_state_nxt = S_DONE;
        end else if (WD_ENABLED && (r_wd == WD_EXPIRE)) begin
          w_to_nxt    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_grant_nxt       = w_gnt_oh;
        w_done_nxt        = w_gnt_oh;
        w_busy_nxt        = 1'b1;
        w_timeout_err_nxt = r_to;
        w_ptr_nxt         = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);
        w_state_nxt       = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, arbitration context and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_wd          <= '0;
      r_to          <= 1'b0;
      r_grant       <= '0;
      r_done        <= '0;
      r_unit_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_gidx        <= w_gidx_nxt;
      r_wd          <= w_wd_nxt;
      r_to          <= w_to_nxt;
      r_grant       <= w_grant_nxt;
      r_done        <= w_done_nxt;
      r_unit_start  <= w_unit_start_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_w0rm_timer_arbiter.sv
// Directed bench for w0rm_timer_arbiter: cycle vector table, round-robin,
// pointer skip, watchdog boundaries, spurious stop and reset mid-operation.
module tb_w0rm_timer_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic       unit_start;
  logic       unit_stop;
  logic       busy;
  logic       timeout_err;

  logic [3:0] req_nt;
  logic [3:0] grant_nt;
  logic [3:0] done_nt;
  logic       unit_start_nt;
  logic       unit_stop_nt;
  logic       busy_nt;
  logic       timeout_err_nt;

  logic       vec_stop;
  logic       model_stop;
  logic       model_en;
  int         model_lat;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         nt_done_cnt = 0;

  typedef struct {
    logic [3:0]  req;
    logic        stop;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    bit   en;
    int   lat;
    int   exp_c;
    logic exp_te;
  } wd_t;

  vec_t       vt[12];
  wd_t        wt[5];
  logic [3:0] rr_exp[5];

  always #5 clk = ~clk;

  assign unit_stop    = model_en ? model_stop : vec_stop;
  assign unit_stop_nt = 1'b0;

  w0rm_timer_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .unit_start  (unit_start),
    .unit_stop   (unit_stop),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  w0rm_timer_arbiter #(.NUM_REQ(4), .TIMEOUT(0)) u_dut_nt (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req_nt),
    .grant       (grant_nt),
    .done        (done_nt),
    .unit_start  (unit_start_nt),
    .unit_stop   (unit_stop_nt),
    .busy        (busy_nt),
    .timeout_err (timeout_err_nt)
  );

  // Shared-unit model: stop pulse becomes visible model_lat edges after start.
  initial begin
    model_stop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && unit_start) begin
        repeat (model_lat) @(posedge clk);
        #1 model_stop = 1'b1;
        @(posedge clk);
        #1 model_stop = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (done_nt != 4'b0000) nt_done_cnt <= nt_done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [10:0] outs();
    return {grant, done, unit_start, busy, timeout_err};
  endfunction

  function automatic logic [10:0] ex(input logic [3:0] g, input logic [3:0] d,
                                     input logic us, input logic b, input logic te);
    return {g, d, us, b, te};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step();
      if (grant != 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int max_cyc, output int c);
    c = -1;
    for (int i = 1; i <= max_cyc && c < 0; i++) begin
      step();
      if (done != 4'b0000) c = i;
    end
  endtask

  task automatic do_reset();
    req     = 4'b0000;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    reset_n   = 1'b0;
    req       = 4'b0000;
    req_nt    = 4'b0001;
    vec_stop  = 1'b0;
    model_en  = 1'b0;
    model_lat = 4;

    // Single request, stop visible 4 cycles after unit_start, then spurious stop.
    vt[0]  = '{4'b0001, 1'b0, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
    vt[1]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0)};
    vt[2]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0)};
    vt[3]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0)};
    vt[4]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0)};
    vt[5]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0)};
    vt[6]  = '{4'b0001, 1'b1, ex(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0)};
    vt[7]  = '{4'b0001, 1'b0, ex(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0)};
    vt[8]  = '{4'b0000, 1'b0, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
    vt[9]  = '{4'b0000, 1'b0, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
    vt[10] = '{4'b0000, 1'b1, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
    vt[11] = '{4'b0000, 1'b0, ex(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};

    // Watchdog boundary rows: stop latency vs. TIMEOUT=16 expiry.
    wt[0] = '{1'b1, 4,  6,  1'b0};
    wt[1] = '{1'b1, 14, 16, 1'b0};
    wt[2] = '{1'b1, 15, 17, 1'b0};
    wt[3] = '{1'b1, 16, 17, 1'b1};
    wt[4] = '{1'b0, 0,  17, 1'b1};

    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    #2;
    check("reset_state", 32'(outs()), 32'(0));
    step();
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req      = vt[i].req;
      vec_stop = vt[i].stop;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
    vec_stop = 1'b0;

    // Round-robin with all requesters pending.
    do_reset();
    model_en  = 1'b1;
    model_lat = 4;
    req       = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20);
      check($sformatf("rr_grant%0d", k), 32'(grant), 32'(rr_exp[k]));
      wait_done(30, c);
      check($sformatf("rr_done%0d", k), 32'(done), 32'(rr_exp[k]));
      step();
      check($sformatf("rr_gap%0d", k), 32'({grant, busy}), 32'(0));
    end

    // Pointer skip: grant 2, then req 0011 wraps to 0 then 1.
    do_reset();
    req = 4'b0100;
    wait_grant(20);
    check("skip_g2", 32'(grant), 32'(4'b0100));
    req = 4'b0011;
    wait_done(30, c);
    check("skip_d2", 32'(done), 32'(4'b0100));
    wait_grant(20);
    check("skip_g0", 32'(grant), 32'(4'b0001));
    wait_done(30, c);
    wait_grant(20);
    check("skip_g1", 32'(grant), 32'(4'b0010));
    req = 4'b0000;
    wait_done(30, c);
    check("skip_d1", 32'(done), 32'(4'b0010));
    step();

    // Watchdog boundaries, req dropped right after grant in every row.
    for (int r = 0; r < 5; r++) begin
      model_en  = wt[r].en;
      model_lat = wt[r].lat;
      req       = 4'b0001;
      wait_grant(10);
      req = 4'b0000;
      check($sformatf("wd_start%0d", r), 32'(unit_start), 32'(1));
      wait_done(40, c);
      check($sformatf("wd_cycles%0d", r), 32'(c), 32'(wt[r].exp_c));
      check($sformatf("wd_done%0d", r), 32'({done, timeout_err}), 32'({4'b0001, wt[r].exp_te}));
      step();
      check($sformatf("wd_pulse%0d", r), 32'({done, timeout_err}), 32'(0));
    end

    // Reset in the middle of WAIT, then a late stop pulse.
    model_en = 1'b0;
    req      = 4'b0100;
    wait_grant(10);
    step();
    step();
    #3 reset_n = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'(0));
    req = 4'b0000;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    vec_stop = 1'b1;
    step();
    vec_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_late_stop%0d", i), 32'({done, busy}), 32'(0));
    end
    model_en  = 1'b1;
    model_lat = 2;
    req       = 4'b0010;
    wait_grant(10);
    check("rst_regrant", 32'(grant), 32'(4'b0010));
    req = 4'b0000;
    wait_done(30, c);
    check("rst_redone", 32'(done), 32'(4'b0010));
    step();

    // Reset must bring the pointer back to 0 (it is 2 here).
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req     = 4'b1001;
    wait_grant(10);
    check("rst_ptr", 32'(grant), 32'(4'b0001));
    req = 4'b0000;
    wait_done(30, c);
    step();
    step();

    // TIMEOUT=0 instance with a unit that never stops stays busy.
    check("nt_busy", 32'({busy_nt, done_nt, timeout_err_nt}), 32'({1'b1, 4'b0000, 1'b0}));
    check("nt_no_done", 32'(nt_done_cnt), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
